mole_scheduler: RTL
===================

Name: mole_scheduler

Overview:
Drives the mole lamps and consumes hit pulses for the whack-a-mole game. It picks a pseudo-random mole and lights it as a one-hot active_mask for a fixed window. It then scores a hit when a matching hit_pulse arrives, or scores a miss on timeout. Outputs feed the switch-hit detector (active_mask), the LED driver, and the score/7-seg display logic.

Parameters:
WIDTH, 18, number of moles/switches (2..32)
ON_CYCLES, 50000000, clocks a mole stays lit (>=2)
GAP_CYCLES, 12500000, dark clocks between moles (>=1)
LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001
SCORE_W, 8, width of hit/miss counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
game_active  in  1  level; 1 = game running
hit_pulse  in  WIDTH  one-cycle toggle pulses from switch-hit detector (already masked, re-masked here)
active_mask  out  WIDTH  one-hot lit mole, 0 when none
mole_idx  out  $clog2(WIDTH)  index of current/last mole
hit_strobe  out  1  one-cycle pulse per scored hit
miss_strobe  out  1  one-cycle pulse per timeout
hit_count  out  SCORE_W  saturating hits this game
miss_count  out  SCORE_W  saturating misses this game

Behaviour:
- Reset: state IDLE, active_mask=0, mole_idx=0, strobes=0, counts=0, LFSR=seed, timer=0. Reset is asynchronous, so assertion mid-game clears everything immediately.
- All outputs are registered.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Advances every clock out of reset, in every state. Never reaches 0.
- Candidate index: cand = lfsr[IDX_W-1:0], where IDX_W=$clog2(WIDTH).
- States IDLE, GAP, PICK, ON; 32-bit down-counter timer.
- IDLE: mask 0. When game_active=1: clear hit_count/miss_count, load timer=GAP_CYCLES-1, go GAP.
- GAP: mask 0. Decrement timer; at timer==0 go PICK.
- PICK: one try per clock.
  - Accept cand if cand<WIDTH and cand!=mole_idx. On accept: mole_idx<=cand, active_mask<=1<<cand, timer<=ON_CYCLES-1, go ON.
  - Otherwise stay in PICK. Consecutive moles are therefore always distinct.
- ON: hit = |(hit_pulse & active_mask).
  - On hit: hit_strobe=1 next cycle, hit_count+1 (saturate at all-ones), mask 0, timer=GAP_CYCLES-1, go GAP.
  - Else if timer==0: miss_strobe=1, miss_count+1 (saturate), mask 0, load gap, go GAP.
  - Else decrement timer.
  - Mask is lit for exactly ON_CYCLES clocks absent a hit.
- Simultaneous hit and timer==0 in the same cycle: hit wins, no miss.
- hit_pulse bits outside active_mask are ignored. Any hit_pulse in IDLE/GAP/PICK is ignored, including a late pulse in the first GAP cycle.
- game_active=0 in any non-IDLE state:
  - Next cycle: IDLE, mask 0, no strobe for an in-flight mole.
  - Counts are held for display until the next game start.
- At most one of hit_strobe/miss_strobe is high in any cycle.

Optional Feature:
MOLE_SPEEDUP_EN
- Defined: adds on_len register (reset/game start = ON_CYCLES) used instead of ON_CYCLES when loading ON. Each scored hit reduces on_len by on_len>>3, floored at ON_CYCLES>>2. Misses leave it unchanged.
- Undefined: window is constant ON_CYCLES; no extra register.

Test Plan:
1. Reset with WIDTH=18, ON=8, GAP=4 -> all outputs 0; after game_active=1, mask stays 0 for 4 clocks, then goes one-hot after PICK. Mole index is <18.
2. Lit mole k, no hit -> mask high exactly 8 clocks, then miss_strobe one cycle, miss_count=1, mask 0 for 4 clocks, next mole index !=k.
3. Lit mole k, hit_pulse=1<<k on 3rd ON clock -> hit_strobe one cycle later, hit_count=1, mask cleared same edge, no miss_strobe.
4. hit_pulse on bit !=k during ON, and hit_pulse on k during GAP -> no strobes, counts unchanged.
5. hit_pulse on k in the cycle timer==0 -> hit_strobe only, hit_count increments, miss_count unchanged. With SCORE_W=2, 5 hits -> hit_count saturates at 3.
6. game_active deasserted mid-ON -> IDLE next cycle, mask 0, no strobe, counts held. rst_n low mid-ON -> immediate clear. With MOLE_SPEEDUP_EN and ON=64: window lengths after successive hits are 64, 56, 49, ... floored at 16.

Source files
------------

// File: rtl/mole_scheduler.sv
// mole_scheduler: lights one pseudo-random mole at a time and scores it as a hit or a timeout miss.
// Latency: strobes, counts and mask clear are registered, one clock after the deciding cycle.
// Backpressure: none; hit_pulse is sampled every clock and only honoured against the lit mole in ON.
// Optional build macro MOLE_SPEEDUP_EN: each scored hit shortens the lit window.
module mole_scheduler #(
    parameter int          WIDTH      = 18,
    parameter int          ON_CYCLES  = 50000000,
    parameter int          GAP_CYCLES = 12500000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          SCORE_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     game_active,
    input  logic [WIDTH-1:0]         hit_pulse,
    output logic [WIDTH-1:0]         active_mask,
    output logic [$clog2(WIDTH)-1:0] mole_idx,
    output logic                     hit_strobe,
    output logic                     miss_strobe,
    output logic [SCORE_W-1:0]       hit_count,
    output logic [SCORE_W-1:0]       miss_count
);

    localparam int          IDX_W    = $clog2(WIDTH);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] ON_INIT  = 32'(ON_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_PICK, S_ON} state_t;

    state_t             state_q;
    logic [31:0]        timer_q;
    logic [15:0]        lfsr_q;
    logic [15:0]        lfsr_d;
    logic [WIDTH-1:0]   active_mask_q;
    logic [IDX_W-1:0]   mole_idx_q;
    logic               hit_strobe_q;
    logic               miss_strobe_q;
    logic [SCORE_W-1:0] hit_count_q;
    logic [SCORE_W-1:0] miss_count_q;

    logic [IDX_W-1:0]   cand;
    logic               cand_ok;
    logic               hit;
    logic [31:0]        on_load;
    logic [WIDTH-1:0]   cand_mask;

    // Galois LFSR step, taps x^16+x^14+x^13+x^11+1.
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ 16'hB400;
        end
    end

    // Candidate must be a real switch and differ from the previous mole.
    always_comb begin
        cand      = lfsr_q[IDX_W-1:0];
        cand_ok   = (32'(cand) < 32'(WIDTH)) && (cand != mole_idx_q);
        cand_mask = {{(WIDTH-1){1'b0}}, 1'b1} << cand;
        hit       = |(hit_pulse & active_mask_q);
    end

`ifdef MOLE_SPEEDUP_EN
    localparam logic [31:0] ON_FLOOR = ON_INIT >> 2;

    logic [31:0] on_len_q;
    logic [31:0] on_len_d;

    // Shrink the window by one eighth per hit, never below a quarter of the base length.
    always_comb begin
        on_len_d = on_len_q - (on_len_q >> 3);
        if (on_len_d < ON_FLOOR) begin
            on_len_d = ON_FLOOR;
        end
        on_load = on_len_q - 32'd1;
    end
`else
    // Fixed lit window.
    always_comb begin
        on_load = ON_INIT - 32'd1;
    end
`endif

    // Game FSM with registered outputs; LFSR free-runs in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            lfsr_q        <= SEED;
            active_mask_q <= '0;
            mole_idx_q    <= '0;
            hit_strobe_q  <= 1'b0;
            miss_strobe_q <= 1'b0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
`ifdef MOLE_SPEEDUP_EN
            on_len_q      <= ON_INIT;
`endif
        end else begin
            lfsr_q        <= lfsr_d;
            hit_strobe_q  <= 1'b0;
            miss_strobe_q <= 1'b0;
            if (state_q != S_IDLE && !game_active) begin
                // Abort: drop the in-flight mole silently, keep counts for display.
                state_q       <= S_IDLE;
                active_mask_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        active_mask_q <= '0;
                        if (game_active) begin
                            hit_count_q  <= '0;
                            miss_count_q <= '0;
                            timer_q      <= GAP_LOAD;
                            state_q      <= S_GAP;
`ifdef MOLE_SPEEDUP_EN
                            on_len_q     <= ON_INIT;
`endif
                        end
                    end
                    S_GAP: begin
                        if (timer_q == 32'd0) begin
                            state_q <= S_PICK;
                        end else begin
                            timer_q <= timer_q - 32'd1;
                        end
                    end
                    S_PICK: begin
                        if (cand_ok) begin
                            mole_idx_q    <= cand;
                            active_mask_q <= cand_mask;
                            timer_q       <= on_load;
                            state_q       <= S_ON;
                        end
                    end
                    S_ON: begin
                        // A hit in the final lit cycle beats the timeout.
                        if (hit) begin
                            hit_strobe_q  <= 1'b1;
                            if (hit_count_q != '1) begin
                                hit_count_q <= hit_count_q + 1'b1;
                            end
                            active_mask_q <= '0;
                            timer_q       <= GAP_LOAD;
                            state_q       <= S_GAP;
`ifdef MOLE_SPEEDUP_EN
                            on_len_q      <= on_len_d;
`endif
                        end else if (timer_q == 32'd0) begin
                            miss_strobe_q <= 1'b1;
                            if (miss_count_q != '1) begin
                                miss_count_q <= miss_count_q + 1'b1;
                            end
                            active_mask_q <= '0;
                            timer_q       <= GAP_LOAD;
                            state_q       <= S_GAP;
                        end else begin
                            timer_q <= timer_q - 32'd1;
                        end
                    end
                    default: begin
                        state_q       <= S_IDLE;
                        active_mask_q <= '0;
                    end
                endcase
            end
        end
    end

    assign active_mask = active_mask_q;
    assign mole_idx    = mole_idx_q;
    assign hit_strobe  = hit_strobe_q;
    assign miss_strobe = miss_strobe_q;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;

endmodule
